// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 keyboard receive path: the frame state
// encoding, the scan-code prefix bytes, the direction key codes and the
// default inter-edge timeout.
package ps2_pkg;

    // Frame receiver states: waiting for a start bit, shifting the eight data
    // bits, capturing the parity bit, and checking the stop bit.
    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frameState_t;

    // Prefix bytes: 0xE0 marks an extended code, 0xF0 marks a key release.
    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    // Extended (arrow key) codes.
    localparam logic [7:0] KEY_EXT_UP    = 8'h75;
    localparam logic [7:0] KEY_EXT_DOWN  = 8'h72;
    localparam logic [7:0] KEY_EXT_RIGHT = 8'h74;
    localparam logic [7:0] KEY_EXT_LEFT  = 8'h6B;

    // Non-extended (W/S/D/A letter key) codes.
    localparam logic [7:0] KEY_UP    = 8'h1D;
    localparam logic [7:0] KEY_DOWN  = 8'h1B;
    localparam logic [7:0] KEY_RIGHT = 8'h23;
    localparam logic [7:0] KEY_LEFT  = 8'h1C;

    // Clock cycles without a PS/2 falling edge before a partial frame is
    // dropped: 1 ms at 50 MHz.
    localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
// Synchronizes the raw PS/2 clock and data lines, detects keyboard clock
// falling edges, and assembles 11-bit frames (start, 8 data LSB first, odd
// parity, stop). A partial frame is abandoned if no edge arrives within
// TIMEOUT_CYCLES.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   ps2_clk_i    raw keyboard clock (asynchronous)
//   ps2_data_i   raw keyboard data (asynchronous)
//   byte_valid_o high in the cycle the stop bit of a good frame is sampled
//   byte_o       received data byte, valid alongside byte_valid_o
//   err_o        high in the cycle a parity/stop error or timeout is seen
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       err_o
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]         clkSync_q;
    logic [1:0]         dataSync_q;
    logic               clkPrev_q;
    frameState_t        state_q;
    logic [3:0]         bitCnt_q;
    logic [7:0]         shift_q;
    logic               parity_q;
    logic [TIMER_W-1:0] timer_q;

    logic fallEdge;
    logic dataBit;
    logic stopOk;
    logic timeoutHit;

    // Edge and bit decode. The frame verdict is produced combinationally in the
    // stop-bit sample cycle so that the wrapper can register the byte, the
    // valid pulse and the key levels together one cycle later.
    assign fallEdge     = clkPrev_q & ~clkSync_q[1];
    assign dataBit      = dataSync_q[1];
    assign stopOk       = dataBit & (^{parity_q, shift_q});
    assign timeoutHit   = (state_q != IDLE) && !fallEdge &&
                          (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign byte_valid_o = (state_q == STOP) && fallEdge && stopOk;
    assign err_o        = ((state_q == STOP) && fallEdge && !stopOk) || timeoutHit;
    assign byte_o       = shift_q;

    // Synchronizers, edge history, inactivity timer and the frame FSM. The
    // timer only runs while a frame is in progress and restarts on each edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            clkPrev_q  <= 1'b1;
            state_q    <= IDLE;
            bitCnt_q   <= 4'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            timer_q    <= '0;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2_clk_i};
            dataSync_q <= {dataSync_q[0], ps2_data_i};
            clkPrev_q  <= clkSync_q[1];

            if (fallEdge || state_q == IDLE || timeoutHit) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + 1'b1;
            end

            if (timeoutHit) begin
                state_q  <= IDLE;
                bitCnt_q <= 4'd0;
            end else if (fallEdge) begin
                case (state_q)
                    IDLE: begin
                        // A high data bit on an idle edge is line noise, not
                        // a start bit.
                        if (!dataBit) begin
                            state_q  <= DATA;
                            bitCnt_q <= 4'd0;
                        end
                    end
                    DATA: begin
                        shift_q  <= {dataBit, shift_q[7:1]};
                        bitCnt_q <= bitCnt_q + 4'd1;
                        if (bitCnt_q == 4'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_q <= dataBit;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        state_q  <= IDLE;
                        bitCnt_q <= 4'd0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns accepted PS/2 scan bytes into held levels for the four direction
// keys. Arrow keys (extended codes) and W/A/S/D drive the same levels.
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   ps2_clk_i     raw keyboard clock
//   ps2_data_i    raw keyboard data
//   up_o, down_o, right_o, left_o   key-held levels
//   code_valid_o  one-cycle pulse per accepted byte
//   scan_code_o   last accepted byte
//   frame_err_o   one-cycle pulse on parity/stop error or timeout
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = ps2_pkg::DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       up_o,
    output logic       down_o,
    output logic       right_o,
    output logic       left_o,
    output logic       code_valid_o,
    output logic [7:0] scan_code_o,
    output logic       frame_err_o
);

    import ps2_pkg::*;

    logic       rxValid;
    logic [7:0] rxByte;
    logic       rxErr;

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [3:0] levels_q, levels_d;
    logic       codeValid_q;
    logic [7:0] scanCode_q;
    logic       frameErr_q;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .byte_valid_o(rxValid),
        .byte_o      (rxByte),
        .err_o       (rxErr)
    );

    // Prefix tracking and key-level decode. levels_d is {up, down, right,
    // left}. Any key code or any receive error ends the prefix sequence, so a
    // dropped byte cannot turn the following byte into a release.
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        levels_d = levels_q;
        if (rxValid) begin
            if (rxByte == PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (rxByte == PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (ext_q) begin
                    case (rxByte)
                        KEY_EXT_UP:    levels_d[3] = ~brk_q;
                        KEY_EXT_DOWN:  levels_d[2] = ~brk_q;
                        KEY_EXT_RIGHT: levels_d[1] = ~brk_q;
                        KEY_EXT_LEFT:  levels_d[0] = ~brk_q;
                        default:       levels_d    = levels_q;
                    endcase
                end else begin
                    case (rxByte)
                        KEY_UP:    levels_d[3] = ~brk_q;
                        KEY_DOWN:  levels_d[2] = ~brk_q;
                        KEY_RIGHT: levels_d[1] = ~brk_q;
                        KEY_LEFT:  levels_d[0] = ~brk_q;
                        default:   levels_d    = levels_q;
                    endcase
                end
            end
        end else if (rxErr) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
    end

    // Output registers: pulse, byte and levels all update in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            levels_q    <= 4'b0000;
            codeValid_q <= 1'b0;
            scanCode_q  <= 8'h00;
            frameErr_q  <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            levels_q    <= levels_d;
            codeValid_q <= rxValid;
            frameErr_q  <= rxErr;
            if (rxValid) begin
                scanCode_q <= rxByte;
            end
        end
    end

    assign up_o         = levels_q[3];
    assign down_o       = levels_q[2];
    assign right_o      = levels_q[1];
    assign left_o       = levels_q[0];
    assign code_valid_o = codeValid_q;
    assign scan_code_o  = scanCode_q;
    assign frame_err_o  = frameErr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
// Directed bench for ps2_key_decoder. Frames are bit-banged on the PS/2 pins
// with a short timeout so the inactivity case stays quick to simulate.
module tb_ps2_key_decoder;

    localparam int TIMEOUT = 300;
    localparam int HALF    = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2Clk;
    logic       ps2Data;
    logic       up, down, right, left;
    logic       codeValid;
    logic [7:0] scanCode;
    logic       frameErr;

    int         checkCount  = 0;
    int         errorCount  = 0;
    int         validPulses = 0;
    int         errPulses   = 0;
    logic [7:0] scanAtPulse = 8'h00;
    logic [3:0] levelsAtPulse = 4'h0;
    int         v0, e0;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_i   (ps2Clk),
        .ps2_data_i  (ps2Data),
        .up_o        (up),
        .down_o      (down),
        .right_o     (right),
        .left_o      (left),
        .code_valid_o(codeValid),
        .scan_code_o (scanCode),
        .frame_err_o (frameErr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Pulse monitor: counts high cycles of each pulse and captures what the
    // outputs looked like in the same cycle as code_valid.
    always @(negedge clk) begin
        if (codeValid) begin
            validPulses++;
            scanAtPulse   = scanCode;
            levelsAtPulse = {up, down, right, left};
        end
        if (frameErr) errPulses++;
        if (codeValid || frameErr) checkOutput("valid_err_exclusive", {31'd0, codeValid & frameErr}, 0);
    end

    task automatic sendBit(input logic b);
        ps2Data = b;
        repeat (HALF) @(posedge clk);
        ps2Clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2Clk = 1'b1;
    endtask

    // Sends the first nBits of a frame for code, optionally corrupting the
    // parity or stop bit, then idles the line.
    task automatic applyStimulus(input logic [7:0] code, input logic flipPar,
                                 input logic badStop, input int nBits);
        logic [10:0] frame;
        frame = {~badStop, (~^code) ^ flipPar, code, 1'b0};
        for (int i = 0; i < nBits; i++) sendBit(frame[i]);
        ps2Data = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    task automatic sendByte(input logic [7:0] code);
        applyStimulus(code, 1'b0, 1'b0, 11);
    endtask

    task automatic snap();
        @(negedge clk);
        v0 = validPulses;
        e0 = errPulses;
    endtask

    initial begin
        rst     = 1'b1;
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_levels", {28'd0, up, down, right, left}, 0);
        checkOutput("reset_valid", {31'd0, codeValid}, 0);
        checkOutput("reset_err", {31'd0, frameErr}, 0);
        checkOutput("reset_scan", {24'd0, scanCode}, 0);

        // Make of W, then extended break of the up arrow.
        snap();
        sendByte(8'h1D);
        @(negedge clk);
        checkOutput("w_valid_count", validPulses - v0, 1);
        checkOutput("w_scan", {24'd0, scanCode}, 32'h1D);
        checkOutput("w_up", {31'd0, up}, 1);
        checkOutput("w_scan_at_pulse", {24'd0, scanAtPulse}, 32'h1D);
        checkOutput("w_levels_at_pulse", {28'd0, levelsAtPulse}, 32'h8);
        snap();
        sendByte(8'hE0);
        sendByte(8'hF0);
        checkOutput("brk_up_held_mid", {31'd0, up}, 1);
        sendByte(8'h75);
        @(negedge clk);
        checkOutput("brk_up_valid_count", validPulses - v0, 3);
        checkOutput("brk_up_level", {31'd0, up}, 0);
        checkOutput("brk_up_scan", {24'd0, scanCode}, 32'h75);

        // Right arrow make, typematic repeats, then D release.
        sendByte(8'hE0);
        sendByte(8'h74);
        checkOutput("right_make", {31'd0, right}, 1);
        for (int r = 0; r < 2; r++) begin
            sendByte(8'hE0);
            sendByte(8'h74);
            checkOutput("right_typematic", {31'd0, right}, 1);
        end
        checkOutput("right_levels_at_pulse", {28'd0, levelsAtPulse}, 32'h2);
        sendByte(8'hF0);
        sendByte(8'h23);
        checkOutput("right_release", {31'd0, right}, 0);

        // Corrupted parity, then corrupted stop bit.
        snap();
        applyStimulus(8'h6B, 1'b1, 1'b0, 11);
        @(negedge clk);
        checkOutput("parity_err_count", errPulses - e0, 1);
        checkOutput("parity_no_valid", validPulses - v0, 0);
        checkOutput("parity_left", {31'd0, left}, 0);
        checkOutput("parity_scan", {24'd0, scanCode}, 32'h23);
        snap();
        applyStimulus(8'h6B, 1'b0, 1'b1, 11);
        @(negedge clk);
        checkOutput("stop_err_count", errPulses - e0, 1);
        checkOutput("stop_no_valid", validPulses - v0, 0);
        checkOutput("stop_scan", {24'd0, scanCode}, 32'h23);

        // An error between prefix and key code cancels the prefix.
        snap();
        sendByte(8'hE0);
        applyStimulus(8'h75, 1'b1, 1'b0, 11);
        sendByte(8'h75);
        @(negedge clk);
        checkOutput("ext_cleared_up", {31'd0, up}, 0);
        checkOutput("ext_cleared_valid", validPulses - v0, 2);
        checkOutput("ext_cleared_err", errPulses - e0, 1);
        sendByte(8'hF0);
        applyStimulus(8'h1D, 1'b0, 1'b1, 11);
        sendByte(8'h1D);
        checkOutput("brk_cleared_up", {31'd0, up}, 1);

        // Idle edge with data high is ignored.
        snap();
        sendBit(1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("glitch_no_err", errPulses - e0, 0);
        checkOutput("glitch_no_valid", validPulses - v0, 0);

        // Partial frame after an extended prefix, then timeout.
        sendByte(8'hE0);
        snap();
        applyStimulus(8'h1B, 1'b0, 1'b0, 5);
        repeat (TIMEOUT + 50) @(posedge clk);
        @(negedge clk);
        checkOutput("timeout_err_count", errPulses - e0, 1);
        checkOutput("timeout_no_valid", validPulses - v0, 0);
        sendByte(8'h72);
        checkOutput("timeout_ext_cleared", {31'd0, down}, 0);
        sendByte(8'h1B);
        checkOutput("timeout_then_down", {31'd0, down}, 1);

        // Reset in the middle of a frame.
        snap();
        applyStimulus(8'h1C, 1'b0, 1'b0, 6);
        #3 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (TIMEOUT + 50) @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_levels", {28'd0, up, down, right, left}, 0);
        checkOutput("midrst_scan", {24'd0, scanCode}, 0);
        checkOutput("midrst_no_err", errPulses - e0, 0);
        checkOutput("midrst_no_valid", validPulses - v0, 0);
        sendByte(8'h1C);
        checkOutput("midrst_left", {31'd0, left}, 1);
        checkOutput("midrst_left_scan", {24'd0, scanCode}, 32'h1C);

        $display("[TB] Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
